// File: rtl/snake_pkg.sv
// Shared encodings and grid constants for the snake game datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package snake_pkg;

    // Default playfield size, shared with the eat block and the VGA renderer.
    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;

    // Game state encoding as seen on the state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DIE  = 2'b10
    } state_t;

    // Direction of travel.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // One-hot request bit positions: {up,down,left,right}.
    localparam logic [3:0] REQ_UP    = 4'b1000;
    localparam logic [3:0] REQ_DOWN  = 4'b0100;
    localparam logic [3:0] REQ_LEFT  = 4'b0010;
    localparam logic [3:0] REQ_RIGHT = 4'b0001;

    // Direction that would reverse the snake onto its own neck.
    function automatic dir_t opposite_dir(input dir_t d);
        dir_t o;
        case (d)
            DIR_UP:   o = DIR_DOWN;
            DIR_DOWN: o = DIR_UP;
            DIR_LEFT: o = DIR_RIGHT;
            default:  o = DIR_LEFT;
        endcase
        return o;
    endfunction

    // True when exactly one request bit is set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Map a one-hot request to a direction; only meaningful when is_one_hot(v).
    function automatic dir_t req_to_dir(input logic [3:0] v);
        dir_t d;
        case (v)
            REQ_UP:   d = DIR_UP;
            REQ_DOWN: d = DIR_DOWN;
            REQ_LEFT: d = DIR_LEFT;
            default:  d = DIR_RIGHT;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move timebase: counts 0..TICK_DIV-1 while enabled, flags the last count.
// Latency: tick is high during the final cycle of each TICK_DIV-cycle period.
// Backpressure: none; clr forces the count to zero, en=0 freezes it.
module snake_tick_gen #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running period counter with clear priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game sequencer: state machine, move timebase, head position, length.
// Latency: head/step/length update on the clock edge that ends a tick period.
// Backpressure: none; inputs are sampled every cycle, all outputs are registered.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 2500000,
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int START_X  = 20,
    parameter int START_Y  = 15,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dir_req,
    input  logic       add_length,
    input  logic       self_hit,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic       step,
    output logic [5:0] length,
    output logic [1:0] state,
    output logic       over
);

    localparam logic [5:0] INIT_X   = 6'(START_X);
    localparam logic [5:0] INIT_Y   = 6'(START_Y);
    localparam logic [5:0] INIT_L   = 6'(INIT_LEN);
    localparam logic [5:0] SAT_L    = 6'(MAX_LEN);
    localparam logic [6:0] LIMIT_X  = 7'(GRID_W);
    localparam logic [6:0] LIMIT_Y  = 7'(GRID_H);

    state_t     state_q, state_d;
    dir_t       dir_q, pending_q, eff_dir, req_dir;
    logic [5:0] head_x_q, head_y_q, length_q;
    logic       grow_q, step_q;
    logic       tick, req_ok, wall_hit, do_step;
    logic [6:0] dx, dy, next_x, next_y;

    // Counter is held at zero in IDLE so PLAY always starts a full period.
    snake_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .en   (state_q == ST_PLAY),
        .tick (tick)
    );

    // A request is usable only in PLAY, one-hot, and not a reversal of travel.
    assign req_dir = req_to_dir(dir_req);
    assign req_ok  = (state_q == ST_PLAY) && is_one_hot(dir_req) &&
                     (req_dir != opposite_dir(dir_q));
    // A request landing on the evaluation cycle still counts as the latest write.
    assign eff_dir = req_ok ? req_dir : pending_q;

    // Unit vector of the direction about to be committed, in 7-bit two's complement.
    always_comb begin
        dx = 7'd0;
        dy = 7'd0;
        case (eff_dir)
            DIR_UP:   dy = 7'h7F;
            DIR_DOWN: dy = 7'd1;
            DIR_LEFT: dx = 7'h7F;
            default:  dx = 7'd1;
        endcase
    end

    assign next_x = {1'b0, head_x_q} + dx;
    assign next_y = {1'b0, head_y_q} + dy;
    // Stepping below zero wraps to 127, which the unsigned limit compare also catches.
    assign wall_hit = (next_x >= LIMIT_X) || (next_y >= LIMIT_Y);
    // Self-hit has priority over a move landing on the same cycle.
    assign do_step  = (state_q == ST_PLAY) && tick && !self_hit && !wall_hit;

    // Game state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start launches and restarts, collisions end the game.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (self_hit)              state_d = ST_DIE;
                else if (tick && wall_hit) state_d = ST_DIE;
            end
            ST_DIE: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Head, direction, growth and length bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_x_q  <= INIT_X;
            head_y_q  <= INIT_Y;
            length_q  <= INIT_L;
            dir_q     <= DIR_RIGHT;
            pending_q <= DIR_RIGHT;
            grow_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (req_ok) pending_q <= req_dir;
                    if (do_step) begin
                        head_x_q <= next_x[5:0];
                        head_y_q <= next_y[5:0];
                        dir_q    <= eff_dir;
                        if (grow_q && (length_q < SAT_L)) length_q <= length_q + 6'd1;
                        // A pulse coinciding with this step is kept for the next one.
                        grow_q   <= add_length;
                    end else if (add_length) begin
                        grow_q <= 1'b1;
                    end
                end
                ST_DIE: begin
                    if (start) begin
                        head_x_q  <= INIT_X;
                        head_y_q  <= INIT_Y;
                        length_q  <= INIT_L;
                        dir_q     <= DIR_RIGHT;
                        pending_q <= DIR_RIGHT;
                        grow_q    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Step strobe is registered so it aligns with the new head value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= do_step;
        end
    end

    assign head_x = head_x_q;
    assign head_y = head_y_q;
    assign length = length_q;
    assign step   = step_q;
    assign state  = state_q;
    assign over   = (state_q == ST_DIE);

endmodule

// File: tb/tb_snake_move_ctrl.sv
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dir_req = 4'b0000;
    logic       add_length = 1'b0;
    logic       self_hit = 1'b0;

    logic [5:0] hx1, hy1, len1, hx2, hy2, len2;
    logic [1:0] st1, st2;
    logic       step1, step2, over1, over2;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    snake_move_ctrl #(
        .TICK_DIV (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir_req    (dir_req),
        .add_length (add_length),
        .self_hit   (self_hit),
        .head_x     (hx1),
        .head_y     (hy1),
        .step       (step1),
        .length     (len1),
        .state      (st1),
        .over       (over1)
    );

    snake_move_ctrl #(
        .TICK_DIV (4),
        .START_X  (38),
        .INIT_LEN (62)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir_req    (dir_req),
        .add_length (add_length),
        .self_hit   (self_hit),
        .head_x     (hx2),
        .head_y     (hy2),
        .step       (step2),
        .length     (len2),
        .state      (st2),
        .over       (over2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input bit second, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((second ? step2 : step1) !== 1'b1) && (n < 20));
        total_cnt++;
        if ((second ? step2 : step1) !== 1'b1)
            $display("FAIL step_timeout dut%0d no step within %0d cycles, want step=1", second ? 2 : 1, n);
        else pass_cnt++;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({hx1, hy1} !== {6'd20, 6'd15}) $display("FAIL reset_head got (%0d,%0d) want (20,15)", hx1, hy1);
        else pass_cnt++;
        total_cnt++;
        if ({len1, st1, step1, over1} !== {6'd3, 2'b00, 1'b0, 1'b0})
            $display("FAIL reset_misc got len=%0d st=%b step=%b over=%b want len=3 st=00 step=0 over=0", len1, st1, step1, over1);
        else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_start();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (st1 !== 2'b01) $display("FAIL start_state got %b want 01", st1);
        else pass_cnt++;
        wait_step(1'b0, n);
        total_cnt++;
        if (n !== 4) $display("FAIL first_step_latency got %0d want 4", n);
        else pass_cnt++;
        total_cnt++;
        if ({hx1, hy1} !== {6'd21, 6'd15}) $display("FAIL first_step_head got (%0d,%0d) want (21,15)", hx1, hy1);
        else pass_cnt++;
    endtask

    task automatic test_direction();
        int n;
        dir_req = 4'b0010;   // LEFT while moving RIGHT: must be rejected
        tick();
        total_cnt++;
        if (step1 !== 1'b0) $display("FAIL step_single_cycle got %b want 0", step1);
        else pass_cnt++;
        dir_req = 4'b0000;
        start = 1'b1;        // start in PLAY is ignored
        tick();
        start = 1'b0;
        total_cnt++;
        if (st1 !== 2'b01) $display("FAIL start_in_play got %b want 01", st1);
        else pass_cnt++;
        wait_step(1'b0, n);
        total_cnt++;
        if ({hx1, hy1} !== {6'd22, 6'd15}) $display("FAIL reverse_reject got (%0d,%0d) want (22,15)", hx1, hy1);
        else pass_cnt++;
        dir_req = 4'b1000;   // UP
        tick();
        dir_req = 4'b0000;
        wait_step(1'b0, n);
        total_cnt++;
        if ({hx1, hy1} !== {6'd22, 6'd14}) $display("FAIL turn_up got (%0d,%0d) want (22,14)", hx1, hy1);
        else pass_cnt++;
        dir_req = 4'b0010;   // LEFT now allowed
        tick();
        dir_req = 4'b0000;
        wait_step(1'b0, n);
        total_cnt++;
        if ({hx1, hy1} !== {6'd21, 6'd14}) $display("FAIL turn_left got (%0d,%0d) want (21,14)", hx1, hy1);
        else pass_cnt++;
        dir_req = 4'b0011;   // not one-hot: ignored
        tick();
        dir_req = 4'b0000;
        wait_step(1'b0, n);
        total_cnt++;
        if ({hx1, hy1} !== {6'd20, 6'd14}) $display("FAIL non_onehot got (%0d,%0d) want (20,14)", hx1, hy1);
        else pass_cnt++;
        dir_req = 4'b0100;   // DOWN held as a level
        wait_step(1'b0, n);
        wait_step(1'b0, n);
        dir_req = 4'b0000;
        total_cnt++;
        if ({hx1, hy1} !== {6'd20, 6'd16}) $display("FAIL level_down got (%0d,%0d) want (20,16)", hx1, hy1);
        else pass_cnt++;
    endtask

    task automatic test_growth();
        int n;
        add_length = 1'b1; tick();
        add_length = 1'b0; tick();
        add_length = 1'b1; tick();
        add_length = 1'b0;
        wait_step(1'b0, n);
        total_cnt++;
        if ({hx1, hy1, len1} !== {6'd20, 6'd17, 6'd4})
            $display("FAIL grow_once got (%0d,%0d) len=%0d want (20,17) len=4", hx1, hy1, len1);
        else pass_cnt++;
        wait_step(1'b0, n);
        total_cnt++;
        if (len1 !== 6'd4) $display("FAIL grow_absorbed got len=%0d want 4", len1);
        else pass_cnt++;
        repeat (3) tick();
        add_length = 1'b1;   // lands on the evaluation edge
        tick();
        add_length = 1'b0;
        total_cnt++;
        if ({step1, hx1, hy1, len1} !== {1'b1, 6'd20, 6'd19, 6'd4})
            $display("FAIL grow_coincident got step=%b (%0d,%0d) len=%0d want step=1 (20,19) len=4", step1, hx1, hy1, len1);
        else pass_cnt++;
        wait_step(1'b0, n);
        total_cnt++;
        if ({hx1, hy1, len1} !== {6'd20, 6'd20, 6'd5})
            $display("FAIL grow_deferred got (%0d,%0d) len=%0d want (20,20) len=5", hx1, hy1, len1);
        else pass_cnt++;
    endtask

    task automatic test_self_hit();
        repeat (3) tick();
        self_hit = 1'b1;     // coincides with the evaluation edge
        tick();
        self_hit = 1'b0;
        total_cnt++;
        if ({st1, over1, step1, hx1, hy1} !== {2'b10, 1'b1, 1'b0, 6'd20, 6'd20})
            $display("FAIL self_hit_tick got st=%b over=%b step=%b (%0d,%0d) want st=10 over=1 step=0 (20,20)", st1, over1, step1, hx1, hy1);
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if ({st1, hx1, hy1, len1} !== {2'b10, 6'd20, 6'd20, 6'd5})
            $display("FAIL die_frozen got st=%b (%0d,%0d) len=%0d want st=10 (20,20) len=5", st1, hx1, hy1, len1);
        else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({st1, over1, hx1, hy1, len1} !== {2'b00, 1'b0, 6'd20, 6'd15, 6'd3})
            $display("FAIL restart got st=%b over=%b (%0d,%0d) len=%0d want st=00 over=0 (20,15) len=3", st1, over1, hx1, hy1, len1);
        else pass_cnt++;
        repeat (6) tick();
        total_cnt++;
        if ({st1, hx1, hy1} !== {2'b00, 6'd20, 6'd15}) $display("FAIL idle_hold got st=%b (%0d,%0d) want st=00 (20,15)", st1, hx1, hy1);
        else pass_cnt++;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        self_hit = 1'b1;     // mid-period hit
        tick();
        self_hit = 1'b0;
        total_cnt++;
        if ({st1, hx1} !== {2'b10, 6'd20}) $display("FAIL self_hit_mid got st=%b x=%0d want st=10 x=20", st1, hx1);
        else pass_cnt++;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        start = 1'b1; tick(); start = 1'b0;
        wait_step(1'b0, n);
        #3;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({st1, hx1, hy1, len1, step1, over1} !== {2'b00, 6'd20, 6'd15, 6'd3, 1'b0, 1'b0})
            $display("FAIL async_reset got st=%b (%0d,%0d) len=%0d step=%b over=%b want st=00 (20,15) len=3 step=0 over=0",
                     st1, hx1, hy1, len1, step1, over1);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        int n;
        pulse_reset();
        start = 1'b1; tick(); start = 1'b0;
        dir_req = 4'b1000;
        add_length = 1'b1;
        tick();
        dir_req = 4'b0000;
        add_length = 1'b0;
        wait_step(1'b1, n);
        total_cnt++;
        if ({hx2, hy2, len2} !== {6'd38, 6'd14, 6'd63})
            $display("FAIL grow_to_max got (%0d,%0d) len=%0d want (38,14) len=63", hx2, hy2, len2);
        else pass_cnt++;
        add_length = 1'b1; tick(); add_length = 1'b0;
        wait_step(1'b1, n);
        total_cnt++;
        if ({hx2, hy2, len2} !== {6'd38, 6'd13, 6'd63})
            $display("FAIL len_saturate got (%0d,%0d) len=%0d want (38,13) len=63", hx2, hy2, len2);
        else pass_cnt++;
    endtask

    task automatic test_wall();
        int n;
        int steps_seen;
        pulse_reset();
        start = 1'b1; tick(); start = 1'b0;
        wait_step(1'b1, n);
        total_cnt++;
        if ({hx2, hy2, st2} !== {6'd39, 6'd15, 2'b01})
            $display("FAIL wall_last_cell got (%0d,%0d) st=%b want (39,15) st=01", hx2, hy2, st2);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (st2 !== 2'b01) $display("FAIL wall_early got st=%b want 01", st2);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({st2, over2, step2} !== {2'b10, 1'b1, 1'b0})
            $display("FAIL wall_die got st=%b over=%b step=%b want st=10 over=1 step=0", st2, over2, step2);
        else pass_cnt++;
        steps_seen = 0;
        repeat (4) begin
            tick();
            if (step2 === 1'b1) steps_seen++;
        end
        total_cnt++;
        if ({steps_seen[3:0], hx2, hy2} !== {4'd0, 6'd39, 6'd15})
            $display("FAIL wall_frozen got steps=%0d (%0d,%0d) want steps=0 (39,15)", steps_seen, hx2, hy2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_direction();
        test_growth();
        test_self_hit();
        test_async_reset();
        test_saturate();
        test_wall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
- Game-flow sequencer for the snake datapath.
- Owns the game state machine, the move-tick timebase, the head coordinates and the snake length.
- Head coordinates feed the food/eat block (headX/headY); its addLength pulse comes back here as add_length.
- Also feeds body memory and VGA; checks wall and self collisions and sequences start/play/die.

Parameters:
TICK_DIV, 2500000, clk cycles per move step (>=2)
GRID_W, 40, playfield width in cells (<=64)
GRID_H, 30, playfield height in cells (<=64)
START_X, 20, head X after reset/restart
START_Y, 15, head Y after reset/restart
INIT_LEN, 3, length after reset/restart
MAX_LEN, 63, length saturation value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, debounced start/restart button
dir_req  in  4  one-hot direction request {up,down,left,right}, level or pulse
add_length  in  1  one-cycle pulse from eat block
self_hit  in  1  head overlaps body; sampled in PLAY only
head_x  out  6  current head column
head_y  out  6  current head row
step  out  1  one-cycle pulse when head moved this cycle
length  out  6  current snake length
state  out  2  00 IDLE, 01 PLAY, 10 DIE
over  out  1  high while state==DIE

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-low. While rst=0:
  - state=IDLE; head_x=START_X, head_y=START_Y; length=INIT_LEN.
  - dir=RIGHT; step=0, over=0; tick counter=0; grow flag=0.
- Reset mid-game aborts immediately to these values.
- IDLE:
  - Outputs hold initial values.
  - start -> PLAY next cycle; tick counter cleared on entry.
- PLAY:
  - Tick counter runs 0..TICK_DIV-1.
  - When counter==TICK_DIV-1, a move is evaluated and the counter wraps to 0.
  - First step occurs TICK_DIV cycles after entering PLAY.
- Direction:
  - Any single-hot dir_req is latched into pending_dir, last write wins.
  - A request opposite to the current dir is ignored; a non-one-hot dir_req is ignored.
  - pending_dir becomes dir only at a move evaluation.
- Move evaluation: next = head + unit vector(dir).
  - Wall: if next_x<0, next_x>=GRID_W, next_y<0 or next_y>=GRID_H, go to DIE.
    - Compute in 7-bit signed to detect underflow.
    - head unchanged; step not asserted.
  - Otherwise head<=next and step=1 for exactly that cycle.
- Growth:
  - add_length sets grow flag (sticky); further pulses before the next step are absorbed.
  - On a step with grow flag set: length<=min(length+1, MAX_LEN); flag cleared the same cycle.
  - add_length coincident with a step is applied at the following step.
- Self-hit:
  - self_hit=1 in PLAY -> DIE next cycle.
  - If it coincides with a move evaluation, DIE wins: no step, head not updated.
- DIE:
  - head, length and dir frozen; over=1; tick counter stopped.
  - start -> IDLE with all initial values restored (same as reset except rst path).
- start in PLAY is ignored.
- Outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package snake_pkg holds:
  - state encoding (IDLE/PLAY/DIE) and direction encoding (UP/DOWN/LEFT/RIGHT);
  - opposite-direction function;
  - default grid constants (GRID_W, GRID_H) shared with the eat block and VGA.
- One sub-module: snake_tick_gen (param TICK_DIV; inputs clk, rst, clr, en; output tick).

Test Plan:
- Reset/start: rst=0 then release, TICK_DIV=4 -> head=(20,15), length=3, state=00. Pulse start -> state=01; first step 4 cycles later with head=(21,15).
- Reverse rejection: in PLAY moving RIGHT, dir_req=LEFT -> next step head_x+1. Then UP, then LEFT before the next tick -> head moves to (x-1,y-1) over two steps.
- Wall: START_X=38 moving RIGHT -> step to (39,15). Next evaluation -> state=10, over=1, head stays (39,15), no step pulse.
- Growth: pulse add_length twice between ticks -> exactly one increment to 4 at the next step. With length=63, add_length + step -> length stays 63.
- Self-hit: self_hit=1 in the same cycle as the tick -> DIE, head unchanged. Then start -> IDLE with (20,15), length 3.
- Async reset mid-PLAY: drop rst between clock edges -> outputs return to reset values immediately, without waiting for clk.
